// File: rtl/tweet_buffer.sv
// Serial tweet capture buffer: 8N1 receive into a length-tracked message store, replay on a play edge.
// Optional live echo of typed characters is enabled with `define TWEET_ECHO_EN.
module tweet_buffer #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter int         MAX_LEN      = 160,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] BS_CODE      = 8'h08
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              active,
  input  logic              serial_in,
  input  logic              btn_play,
  input  logic              clear,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] length,
  output logic              full,
  output logic              playing,
  output logic              rx_drop,
  output logic              serial_echo
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] MAX_L    = ADDR_W'(MAX_LEN);
  localparam int                IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_SEND, P_ACK, P_WAIT} play_state_t;

  rx_state_t         rx_state;
  play_state_t       play_state;
  logic              rx_meta, rx_sync;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_shift;
  logic              rx_vld_p0, rx_ferr_p0;
  logic              btn_q1, btn_q2;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [7:0]        mem [MAX_LEN];
  logic [7:0]        mem_rd;
  logic              is_bs, cmt_ok, cmt_wr, cmt_bs, cmt_drop, play_go;

  // Stage p0: two-flop synchroniser and 8N1 framing
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      bit_idx    <= '0;
      rx_vld_p0  <= 1'b0;
      rx_ferr_p0 <= 1'b0;
    end else begin
      rx_vld_p0  <= 1'b0;
      rx_ferr_p0 <= 1'b0;
      if (!active) begin
        rx_state <= R_IDLE;
        rx_cnt   <= '0;
      end else begin
        case (rx_state)
          R_IDLE: begin
            rx_cnt  <= '0;
            bit_idx <= '0;
            if (!rx_sync) rx_state <= R_START;
          end
          R_START: begin
            if (rx_cnt == HALF_CNT) begin
              rx_cnt   <= '0;
              rx_state <= rx_sync ? R_IDLE : R_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (rx_cnt == FULL_CNT) begin
              rx_cnt  <= '0;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) rx_state <= R_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (rx_cnt == FULL_CNT) begin
              rx_cnt   <= '0;
              rx_state <= R_IDLE;
              if (rx_sync) rx_vld_p0  <= 1'b1;
              else         rx_ferr_p0 <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (active && rx_state == R_DATA && rx_cnt == FULL_CNT)
      rx_shift <= {rx_sync, rx_shift[7:1]};
  end

  // Stage p1: commit received byte into the buffer and run playback
  assign full     = (length == MAX_L);
  assign is_bs    = (rx_shift == BS_CODE);
  assign cmt_ok   = rx_vld_p0 & ~clear;
  assign cmt_drop = cmt_ok & (playing | (~is_bs & full));
  assign cmt_wr   = cmt_ok & ~playing & ~is_bs & ~full;
  assign cmt_bs   = cmt_ok & ~playing & is_bs & (length != '0);
  assign ptr_nxt  = ptr + 1'b1;
  assign mem_rd   = mem[ptr[IDX_W-1:0]];
  // A commit landing this cycle changes length, so playback waits for the next edge.
  assign play_go  = btn_q1 & ~btn_q2 & active & (rx_state == R_IDLE) &
                    ~rx_vld_p0 & (length != '0);

  always_ff @(posedge sysclk) begin
    if (cmt_wr) mem[length[IDX_W-1:0]] <= rx_shift;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      play_state <= P_IDLE;
      length     <= '0;
      ptr        <= '0;
      playing    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      rx_drop    <= 1'b0;
      btn_q1     <= 1'b0;
      btn_q2     <= 1'b0;
    end else begin
      btn_q1   <= btn_play;
      btn_q2   <= btn_q1;
      tx_start <= 1'b0;
      rx_drop  <= rx_ferr_p0 | cmt_drop;

      if (clear)       length <= '0;
      else if (cmt_wr) length <= length + 1'b1;
      else if (cmt_bs) length <= length - 1'b1;

      if (clear || !active) begin
        play_state <= P_IDLE;
        playing    <= 1'b0;
      end else begin
        case (play_state)
          P_IDLE: begin
            if (play_go) begin
              ptr        <= '0;
              playing    <= 1'b1;
              play_state <= P_SEND;
            end
          end
          P_SEND: begin
            if (!tx_busy) begin
              tx_data    <= mem_rd;
              tx_start   <= 1'b1;
              play_state <= P_ACK;
            end
          end
          P_ACK: begin
            if (tx_busy) play_state <= P_WAIT;
          end
          P_WAIT: begin
            if (!tx_busy) begin
              if (ptr_nxt == length) begin
                playing    <= 1'b0;
                play_state <= P_IDLE;
              end else begin
                ptr        <= ptr_nxt;
                play_state <= P_SEND;
              end
            end
          end
          default: play_state <= P_IDLE;
        endcase
      end
    end
  end

`ifdef TWEET_ECHO_EN
  assign serial_echo = (playing || full) ? 1'b1 : serial_in;
`else
  assign serial_echo = 1'b1;
`endif

endmodule

// File: tb/tb_tweet_buffer.sv
// Scoreboard bench for tweet_buffer: queue-based message model, transmitter model, randomized traffic.
module tb_tweet_buffer;
  localparam int CPB = 16;
  localparam int ML  = 4;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       active = 1'b0;
  logic       serial_in = 1'b1;
  logic       btn_play = 1'b0;
  logic       clear = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] length;
  logic       full, playing, rx_drop, serial_echo;

  tweet_buffer #(.CLKS_PER_BIT(CPB), .MAX_LEN(ML), .ADDR_W(8), .BS_CODE(8'h08)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .active(active), .serial_in(serial_in),
    .btn_play(btn_play), .clear(clear), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .length(length), .full(full), .playing(playing),
    .rx_drop(rx_drop), .serial_echo(serial_echo)
  );

  always #5 sysclk = ~sysclk;

  int n_pass = 0;
  int n_total = 0;
  int exp_drops = 0;
  int n_tx_start = 0;
  int busy_len = 3;
  int busy_cnt = 0;
  byte unsigned model[$];
  byte unsigned exp_tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Transmitter model: busy from the cycle after tx_start for busy_len cycles
  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end
  end

  // Monitor: pops expected bytes and expected drops as the DUT presents them
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (tx_start) begin
        n_tx_start++;
        if (exp_tx.size() == 0) begin
          n_total++;
          $display("FAIL tx_start_unexpected: got tx_data %0h, required no tx_start", tx_data);
        end else begin
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
        end
      end
      if (rx_drop) begin
        n_total++;
        if (exp_drops > 0) begin
          n_pass++;
          exp_drops--;
        end else begin
          $display("FAIL rx_drop_unexpected: got pulse, required none");
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    chk({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
    chk({tag, "_length"}, {24'h0, length}, 32'h0);
    chk({tag, "_full"}, {31'h0, full}, 32'h0);
    chk({tag, "_playing"}, {31'h0, playing}, 32'h0);
    chk({tag, "_rx_drop"}, {31'h0, rx_drop}, 32'h0);
    chk({tag, "_serial_echo"}, {31'h0, serial_echo}, 32'h1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic echo_exp;
`ifdef TWEET_ECHO_EN
    echo_exp = (model.size() < ML) ? 1'b0 : 1'b1;
`else
    echo_exp = 1'b1;
`endif
    if (!stop) exp_drops++;
    else if (b == 8'h08) begin
      if (model.size() > 0) void'(model.pop_back());
    end else if (model.size() < ML) model.push_back(b);
    else exp_drops++;

    serial_in = 1'b0;
    tick(CPB / 2);
    chk("echo_start_bit", {31'h0, serial_echo}, {31'h0, echo_exp});
    tick(CPB - CPB / 2);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(CPB);
    end
    serial_in = stop;
    tick(CPB);
    serial_in = 1'b1;
    tick(4);
    chk("length", {24'h0, length}, model.size());
    chk("full", {31'h0, full}, (model.size() == ML) ? 32'h1 : 32'h0);
    chk("drops_outstanding", exp_drops, 0);
  endtask

  task automatic play(input bit lat);
    int i;
    int len0;
    len0 = model.size();
    for (i = 0; i < 200 && tx_busy; i++) tick();
    foreach (model[k]) exp_tx.push_back(model[k]);
    btn_play = 1'b1;
    if (lat && len0 > 0) begin
      tick(); chk("latency_c1", {31'h0, tx_start}, 32'h0);
      tick(); chk("latency_c2", {31'h0, tx_start}, 32'h0);
      tick(); chk("latency_c3", {31'h0, tx_start}, 32'h1);
    end else begin
      tick(3);
    end
    btn_play = 1'b0;
    if (len0 == 0) begin
      chk("play_empty_ignored", {31'h0, playing}, 32'h0);
    end else begin
      for (i = 0; i < 3000 && (playing || exp_tx.size() != 0); i++) tick();
      chk("play_done", {31'h0, playing}, 32'h0);
      chk("play_all_sent", exp_tx.size(), 0);
      chk("tx_data_hold", {24'h0, tx_data}, {24'h0, model[len0-1]});
    end
    chk("length_after_play", {24'h0, length}, len0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    exp_tx.delete();
    chk("clear_length", {24'h0, length}, 32'h0);
    chk("clear_playing", {31'h0, playing}, 32'h0);
  endtask

  task automatic wait_first_start();
    int i;
    for (i = 0; i < 500 && exp_tx.size() == model.size(); i++) tick();
    chk("first_tx_start_seen", (exp_tx.size() < model.size()) ? 32'h1 : 32'h0, 32'h1);
  endtask

  initial begin
    logic [7:0] b;
    int n0;
    int r;
    active = 1'b1;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick(3);

    send_frame(8'h48, 1'b1);
    send_frame(8'h69, 1'b1);
    play(1'b1);
    do_clear();

    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    send_frame(8'h08, 1'b1);
    send_frame(8'h43, 1'b1);
    play(1'b0);
    do_clear();

    send_frame(8'h08, 1'b1);
    for (int i = 0; i < 5; i++) send_frame(8'h61 + 8'(i), 1'b1);
    do_clear();

    send_frame(8'h5a, 1'b1);
    send_frame(8'h55, 1'b0);
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(40);
    chk("glitch_length", {24'h0, length}, model.size());
    play(1'b0);
    do_clear();

    // Clear in the middle of a slow playback
    for (int i = 0; i < 4; i++) send_frame(8'h30 + 8'(i), 1'b1);
    busy_len = 20;
    foreach (model[k]) exp_tx.push_back(model[k]);
    btn_play = 1'b1;
    wait_first_start();
    btn_play = 1'b0;
    tick(5);
    do_clear();
    n0 = n_tx_start;
    tick(80);
    chk("no_tx_after_clear", n_tx_start - n0, 0);

    // Deassert active in the middle of playback: aborts, contents kept
    for (int i = 0; i < 3; i++) send_frame(8'h70 + 8'(i), 1'b1);
    foreach (model[k]) exp_tx.push_back(model[k]);
    btn_play = 1'b1;
    wait_first_start();
    btn_play = 1'b0;
    tick(5);
    active = 1'b0;
    tick();
    exp_tx.delete();
    chk("inactive_playing", {31'h0, playing}, 32'h0);
    chk("inactive_length", {24'h0, length}, model.size());
    tick(2);
    active = 1'b1;
    n0 = n_tx_start;
    tick(60);
    chk("no_tx_after_inactive", n_tx_start - n0, 0);
    busy_len = 3;
    play(1'b0);

    // Reset mid-playback
    foreach (model[k]) exp_tx.push_back(model[k]);
    busy_len = 20;
    btn_play = 1'b1;
    wait_first_start();
    btn_play = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_play");
    model.delete();
    exp_tx.delete();
    exp_drops = 0;
    tick(2);
    reset_n = 1'b1;
    busy_len = 3;
    tick(3);

    // Reset mid-frame
    send_frame(8'h21, 1'b1);
    serial_in = 1'b0;
    tick(40);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_frame");
    model.delete();
    serial_in = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(40);
    chk("post_reset_length", {24'h0, length}, 32'h0);

    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h08 : 8'($urandom_range(32, 126));
        send_frame(b, 1'b1);
      end else if (r == 5) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0);
      end else if (r <= 7) begin
        busy_len = $urandom_range(1, 6);
        play(1'b0);
      end else if (r == 8) begin
        do_clear();
      end else begin
        serial_in = 1'b0;
        tick($urandom_range(1, 5));
        serial_in = 1'b1;
        tick(30);
        chk("rand_glitch_length", {24'h0, length}, model.size());
      end
    end
    tick(10);
    chk("final_drops_outstanding", exp_drops, 0);
    chk("final_tx_outstanding", exp_tx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tweet_buffer.md
Name: tweet_buffer

Overview:
Parametrised successor to the single-message tweet capture block. It receives 8N1 serial characters and stores them in an internal message buffer of up to MAX_LEN characters, handling backspace. On a play request it replays the stored message byte-by-byte to the serial transmitter over a start/busy handshake. Message length is tracked by a counter rather than per-entry valid bits, so a clear takes one cycle.

Parameters:
CLKS_PER_BIT, 5208, sysclk cycles per serial bit (min 4)
MAX_LEN, 160, maximum stored characters (1..2**ADDR_W-1)
ADDR_W, 8, buffer index width
BS_CODE, 8'h08, character treated as backspace

Ports:
sysclk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
active  in  1  block enable; low aborts RX/playback, buffer retained
serial_in  in  1  serial line, idle high
btn_play  in  1  debounced play request, level; rising edge acts
clear  in  1  sync pulse: empty the buffer
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy; rises within 2 cycles of tx_start
length  out  ADDR_W  stored character count
full  out  1  length == MAX_LEN
playing  out  1  playback in progress
rx_drop  out  1  one-cycle pulse: received char discarded
serial_echo  out  1  echo line (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except serial_echo=1. Length=0, both FSMs idle, btn edge register cleared to 0.
- RX FSM: R_IDLE -> R_START on serial_in=0 while active.
- R_START: at count CLKS_PER_BIT/2, resample. If high, false start -> R_IDLE; otherwise restart the counter -> R_DATA.
- R_DATA: 8 bits LSB first, each sampled at full CLKS_PER_BIT from the previous sample point (mid-bit) -> R_STOP.
- R_STOP: sample at mid-bit. If 0, framing error: discard, pulse rx_drop, -> R_IDLE. If 1, commit the byte -> R_IDLE.
- Commit rules, all in one cycle:
  - byte==BS_CODE and length>0: length-1.
  - byte==BS_CODE and length==0: no-op, no drop.
  - byte!=BS_CODE and length<MAX_LEN: mem[length]<=byte, length+1.
  - byte!=BS_CODE and full: rx_drop.
  - any commit while playing=1: discarded with rx_drop, buffer unchanged.
- Play FSM: P_IDLE -> P_SEND on btn_play rising edge when active, RX in R_IDLE, and length>0. Otherwise the edge is ignored, not queued. Sets ptr=0 and playing=1.
- P_SEND: when tx_busy=0, drive tx_data=mem[ptr] and tx_start=1 for one cycle -> P_ACK.
- P_ACK: wait for tx_busy=1 -> P_WAIT.
- P_WAIT: wait for tx_busy=0, then ptr+1. If ptr+1==length -> P_IDLE (playing=0); else -> P_SEND.
- tx_data holds its last value after playback.
- Playback latency: tx_start rises 2 cycles after the btn_play edge is sampled, provided tx_busy=0.
- clear: length<=0 and playback aborted to P_IDLE. Clear wins over a commit in the same cycle; an in-flight RX frame continues and commits normally afterward.
- active=0: both FSMs forced idle next cycle; length and contents preserved; tx_start=0.
- Length arithmetic saturates: never below 0, never above MAX_LEN. ptr is ADDR_W bits wide.

Optional Feature:
Macro TWEET_ECHO_EN.
- Defined: serial_echo = serial_in when playing=0 and full=0, else 1. This gives live echo of typed characters that stops at the limit.
- Undefined: serial_echo constant 1; no echo logic synthesised. Port remains present.

Test Plan:
- CLKS_PER_BIT=16; send "Hi" (0x48,0x69) -> length=2, no rx_drop. Play -> tx_data 0x48 then 0x69 with one tx_start each, then playing=0.
- Send 'A','B',0x08,'C' -> length=2. Playback emits 0x41,0x43.
- 0x08 with length=0 -> length stays 0, rx_drop=0. With MAX_LEN=4, send 5 chars -> length=4, full=1, one rx_drop on the 5th.
- Stop bit forced 0 on 0x55 -> rx_drop pulse, length unchanged. A 4-cycle low glitch -> no frame, RX back to idle.
- Play with a model holding tx_busy 20 cycles per byte; assert clear mid-message -> no further tx_start, length=0, playing=0 next cycle.
- reset_n low mid-frame and mid-playback -> all outputs reset immediately. With TWEET_ECHO_EN, serial_echo follows serial_in when not full and is 1 when full or playing.
